// File: rtl/bf_mem_arbiter_if.sv
// rtl/bf_mem_arbiter_if.sv - requester and memory-side signal bundle for bf_mem_arbiter
interface bf_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_ack;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] host_rdata;
  logic              host_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Requesters and the memory macro, seen from outside the arbiter
  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_rdata, core_ack,
    output host_req, host_we, host_addr, host_wdata,
    input  host_rdata, host_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  // The arbiter itself
  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_rdata, core_ack,
    input  host_req, host_we, host_addr, host_wdata,
    output host_rdata, host_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/bf_mem_arbiter.sv
// rtl/bf_mem_arbiter.sv - round-robin core/host arbiter for the single-port program/data memory
module bf_mem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              nreset,
  bf_mem_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // WAIT spends MEM_LAT cycles, counting down to zero on the capture cycle
  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

  state_t            r_state;
  state_t            w_next;

  // Owner encoding: 0 = core, 1 = host
  logic              r_owner;
  logic              r_last_grant;
  logic              r_we;
  logic [2:0]        r_cnt;

  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_core_rdata;
  logic [DATA_W-1:0] r_host_rdata;
  logic              r_core_ack;
  logic              r_host_ack;

  logic              w_grant;
  logic              w_grant_host;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // Next state and grant decision; on a tie the requester not served last wins
  always_comb begin
    w_next       = r_state;
    w_grant      = 1'b0;
    w_grant_host = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.core_req && bus.host_req) begin
          w_grant      = 1'b1;
          w_grant_host = ~r_last_grant;
        end else if (bus.core_req) begin
          w_grant      = 1'b1;
        end else if (bus.host_req) begin
          w_grant      = 1'b1;
          w_grant_host = 1'b1;
        end
        if (w_grant) w_next = S_ISSUE;
      end
      S_ISSUE: w_next = r_we ? S_DONE : S_WAIT;
      S_WAIT:  if (r_cnt == 3'd0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    w_sel_we    = w_grant_host ? bus.host_we    : bus.core_we;
    w_sel_addr  = w_grant_host ? bus.host_addr  : bus.core_addr;
    w_sel_wdata = w_grant_host ? bus.host_wdata : bus.core_wdata;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!nreset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Latched request, latency counter and registered outputs
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_cnt        <= 3'd0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_core_rdata <= '0;
      r_host_rdata <= '0;
      r_core_ack   <= 1'b0;
      r_host_ack   <= 1'b0;
    end else begin
      // The strobe is only ever raised on the IDLE->ISSUE edge, so one per transaction
      r_mem_en <= w_grant;
      r_mem_we <= w_grant && w_sel_we;
      if (w_grant) begin
        r_owner      <= w_grant_host;
        r_last_grant <= w_grant_host;
        r_we         <= w_sel_we;
        r_mem_addr   <= w_sel_addr;
        r_mem_wdata  <= w_sel_wdata;
      end
      if (r_state == S_ISSUE)                        r_cnt <= LAT_LOAD;
      else if (r_state == S_WAIT && r_cnt != 3'd0)   r_cnt <= r_cnt - 3'd1;
      if (r_state == S_WAIT && r_cnt == 3'd0) begin
        if (r_owner) r_host_rdata <= bus.mem_rdata;
        else         r_core_rdata <= bus.mem_rdata;
      end
      r_core_ack <= (w_next == S_DONE) && !r_owner;
      r_host_ack <= (w_next == S_DONE) &&  r_owner;
    end
  end

  assign bus.mem_en     = r_mem_en;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.core_rdata = r_core_rdata;
  assign bus.core_ack   = r_core_ack;
  assign bus.host_rdata = r_host_rdata;
  assign bus.host_ack   = r_host_ack;
endmodule

// File: tb/tb_bf_mem_arbiter.sv
// tb/tb_bf_mem_arbiter.sv - self-checking bench for bf_mem_arbiter
module tb_bf_mem_arbiter;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;

  // Cycle counter used to measure request-to-ack latency
  always @(posedge clk) cyc <= cyc + 1;

  bf_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) if1 ();
  bf_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) if3 ();

  bf_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1)) u_dut1 (
    .clk    (clk),
    .nreset (nreset),
    .bus    (if1.slave)
  );

  bf_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(3)) u_dut3 (
    .clk    (clk),
    .nreset (nreset),
    .bus    (if3.slave)
  );

  logic [7:0] mem1 [0:255];
  logic [7:0] mem3 [0:255];
  logic [7:0] rd1;
  logic [7:0] p3_0, p3_1, p3_2;

  // Memory for the MEM_LAT=1 instance; 0xEE on cycles with no valid read data
  always @(posedge clk) begin
    if (if1.mem_en && if1.mem_we) mem1[if1.mem_addr] <= if1.mem_wdata;
    rd1 <= (if1.mem_en && !if1.mem_we) ? mem1[if1.mem_addr] : 8'hEE;
  end
  assign if1.mem_rdata = rd1;

  // Memory for the MEM_LAT=3 instance, three-stage read pipeline
  always @(posedge clk) begin
    if (if3.mem_en && if3.mem_we) mem3[if3.mem_addr] <= if3.mem_wdata;
    p3_0 <= (if3.mem_en && !if3.mem_we) ? mem3[if3.mem_addr] : 8'hEE;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign if3.mem_rdata = p3_2;

  typedef struct packed {
    logic       host;
    logic       we;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic set_req(input bit use3, input bit host, input bit req, input bit we,
                         input logic [7:0] addr, input logic [7:0] wdata);
    if (use3) begin
      if (host) begin
        if3.host_req = req; if3.host_we = we; if3.host_addr = addr; if3.host_wdata = wdata;
      end else begin
        if3.core_req = req; if3.core_we = we; if3.core_addr = addr; if3.core_wdata = wdata;
      end
    end else begin
      if (host) begin
        if1.host_req = req; if1.host_we = we; if1.host_addr = addr; if1.host_wdata = wdata;
      end else begin
        if1.core_req = req; if1.core_we = we; if1.core_addr = addr; if1.core_wdata = wdata;
      end
    end
  endtask

  // Drives one request and reports what the DUT did; comparisons are made by the callers
  task automatic drive_txn(input bit use3, input bit host, input bit we,
                           input logic [7:0] addr, input logic [7:0] wdata, input bit drop_early,
                           output int lat, output bit got_host, output logic [7:0] rdata,
                           output int en_cyc, output int en_cnt, output bit en_we,
                           output bit timeout);
    int  t0;
    bit  en, ca, ha;
    @(posedge clk); #1;
    set_req(use3, host, 1'b1, we, addr, wdata);
    t0 = cyc;
    lat = -1; got_host = 1'b0; rdata = 8'h00;
    en_cyc = -1; en_cnt = 0; en_we = 1'b0; timeout = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      en = use3 ? if3.mem_en : if1.mem_en;
      if (en) begin
        en_cnt++;
        if (en_cyc < 0) begin
          en_cyc = cyc - t0;
          en_we  = use3 ? if3.mem_we : if1.mem_we;
        end
      end
      if (drop_early && (cyc - t0) == 1)
        set_req(use3, host, 1'b0, ~we, ~addr, ~wdata);
      ca = use3 ? if3.core_ack : if1.core_ack;
      ha = use3 ? if3.host_ack : if1.host_ack;
      if (ca || ha) begin
        lat      = cyc - t0;
        got_host = ha;
        rdata    = use3 ? (ha ? if3.host_rdata : if3.core_rdata)
                        : (ha ? if1.host_rdata : if1.core_rdata);
        timeout  = 1'b0;
        break;
      end
    end
    set_req(use3, host, 1'b0, we, addr, wdata);
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({if1.mem_en, if1.mem_we, if1.mem_addr, if1.mem_wdata, if1.core_ack, if1.host_ack,
         if1.core_rdata, if1.host_rdata} !== 36'd0)
      begin n_errors++; $display("FAIL reset_outputs: mem_en=%b mem_we=%b addr=%h wdata=%h acks=%b%b rdata=%h/%h, required all 0",
        if1.mem_en, if1.mem_we, if1.mem_addr, if1.mem_wdata, if1.core_ack, if1.host_ack, if1.core_rdata, if1.host_rdata); end
    @(posedge clk); #1;
    nreset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({if1.mem_en, if1.core_ack, if1.host_ack, if3.mem_en, if3.core_ack, if3.host_ack} !== 6'd0)
        begin n_errors++; $display("FAIL idle_quiet cycle %0d: en/ack bits=%b, required 000000", i,
          {if1.mem_en, if1.core_ack, if1.host_ack, if3.mem_en, if3.core_ack, if3.host_ack}); end
    end
  endtask

  task automatic test_core_write();
    int lat, en_cyc, en_cnt; bit got_host, en_we, timeout; logic [7:0] rdata; exp_t e;
    sb.push_back('{host: 1'b0, we: 1'b1, data: 8'h00});
    drive_txn(1'b0, 1'b0, 1'b1, 8'h10, 8'h5A, 1'b0, lat, got_host, rdata, en_cyc, en_cnt, en_we, timeout);
    e = sb.pop_front();
    n_checks++;
    if (timeout !== 1'b0) begin n_errors++; $display("FAIL core_write_timeout: no ack within 20 cycles, required ack"); end
    n_checks++;
    if (en_cyc !== 1 || en_we !== 1'b1 || en_cnt !== 1)
      begin n_errors++; $display("FAIL core_write_strobe: en_cycle=%0d we=%b strobes=%0d, required 1/1/1", en_cyc, en_we, en_cnt); end
    n_checks++;
    if (lat !== 2 || got_host !== e.host)
      begin n_errors++; $display("FAIL core_write_ack: cycle=%0d host=%b, required 2/%b", lat, got_host, e.host); end
    n_checks++;
    if (mem1[8'h10] !== 8'h5A)
      begin n_errors++; $display("FAIL core_write_mem: mem[0x10]=%h, required 5a", mem1[8'h10]); end
  endtask

  task automatic test_read_latency();
    int lat, en_cyc, en_cnt; bit got_host, en_we, timeout; logic [7:0] rdata; exp_t e;
    sb.push_back('{host: 1'b0, we: 1'b0, data: 8'h5A});
    drive_txn(1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0, lat, got_host, rdata, en_cyc, en_cnt, en_we, timeout);
    e = sb.pop_front();
    n_checks++;
    if (lat !== 3 || got_host !== e.host || rdata !== e.data || en_cyc !== 1 || en_we !== 1'b0 || en_cnt !== 1)
      begin n_errors++; $display("FAIL read_lat1: ack_cycle=%0d host=%b rdata=%h en_cycle=%0d we=%b strobes=%0d, required 3/%b/%h/1/0/1",
        lat, got_host, rdata, en_cyc, en_we, en_cnt, e.host, e.data); end
    sb.push_back('{host: 1'b0, we: 1'b1, data: 8'h00});
    drive_txn(1'b1, 1'b0, 1'b1, 8'h10, 8'h5A, 1'b0, lat, got_host, rdata, en_cyc, en_cnt, en_we, timeout);
    e = sb.pop_front();
    n_checks++;
    if (lat !== 2 || got_host !== e.host)
      begin n_errors++; $display("FAIL write_lat3: ack_cycle=%0d host=%b, required 2/%b", lat, got_host, e.host); end
    sb.push_back('{host: 1'b0, we: 1'b0, data: 8'h5A});
    drive_txn(1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0, lat, got_host, rdata, en_cyc, en_cnt, en_we, timeout);
    e = sb.pop_front();
    n_checks++;
    if (lat !== 5 || got_host !== e.host || rdata !== e.data || en_cnt !== 1)
      begin n_errors++; $display("FAIL read_lat3: ack_cycle=%0d host=%b rdata=%h strobes=%0d, required 5/%b/%h/1",
        lat, got_host, rdata, en_cnt, e.host, e.data); end
  endtask

  task automatic test_arbitration();
    int t0, n_acks; exp_t e; bit ha;
    @(posedge clk); #1;
    nreset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nreset = 1'b1;
    set_req(1'b0, 1'b0, 1'b1, 1'b1, 8'h20, 8'hC1);
    set_req(1'b0, 1'b1, 1'b1, 1'b1, 8'h30, 8'hD1);
    t0 = cyc;
    n_acks = 0;
    for (int i = 0; i < 4; i++) sb.push_back('{host: i[0], we: 1'b1, data: 8'h00});
    for (int k = 0; k < 30 && n_acks < 4; k++) begin
      @(negedge clk);
      if (if1.core_ack || if1.host_ack) begin
        ha = if1.host_ack;
        e = sb.pop_front();
        n_checks++;
        if (ha !== e.host || (if1.core_ack && if1.host_ack) || (cyc - t0) !== 2 + 3 * n_acks)
          begin n_errors++; $display("FAIL alternate grant %0d: host=%b core_ack=%b cycle=%0d, required host=%b cycle=%0d",
            n_acks, ha, if1.core_ack, cyc - t0, e.host, 2 + 3 * n_acks); end
        n_acks++;
      end
    end
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    n_checks++;
    if (n_acks !== 4) begin n_errors++; $display("FAIL alternate_count: acks=%0d, required 4", n_acks); sb.delete(); end
    n_checks++;
    if (mem1[8'h20] !== 8'hC1 || mem1[8'h30] !== 8'hD1)
      begin n_errors++; $display("FAIL alternate_mem: mem[20]=%h mem[30]=%h, required c1/d1", mem1[8'h20], mem1[8'h30]); end
  endtask

  task automatic test_loader();
    int lat, en_cyc, en_cnt; bit got_host, en_we, timeout; logic [7:0] rdata; exp_t e;
    logic [31:0] prog;
    logic [7:0]  want [0:3];
    prog = "+[>]";
    want[0] = 8'h2B; want[1] = 8'h5B; want[2] = 8'h3E; want[3] = 8'h5D;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{host: 1'b1, we: 1'b1, data: 8'h00});
      drive_txn(1'b0, 1'b1, 1'b1, 8'(i), prog[31 - 8 * i -: 8], 1'b0, lat, got_host, rdata, en_cyc, en_cnt, en_we, timeout);
      e = sb.pop_front();
      n_checks++;
      if (lat !== 2 || got_host !== e.host)
        begin n_errors++; $display("FAIL load_write %0d: ack_cycle=%0d host=%b, required 2/%b", i, lat, got_host, e.host); end
    end
    for (int i = 0; i < 4; i++) sb.push_back('{host: 1'b0, we: 1'b0, data: want[i]});
    for (int i = 0; i < 4; i++) begin
      drive_txn(1'b0, 1'b0, 1'b0, 8'(i), 8'h00, 1'b0, lat, got_host, rdata, en_cyc, en_cnt, en_we, timeout);
      e = sb.pop_front();
      n_checks++;
      if (lat !== 3 || got_host !== e.host || rdata !== e.data)
        begin n_errors++; $display("FAIL load_read %0d: ack_cycle=%0d host=%b rdata=%h, required 3/%b/%h",
          i, lat, got_host, rdata, e.host, e.data); end
    end
    sb.push_back('{host: 1'b1, we: 1'b0, data: 8'h5B});
    drive_txn(1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, lat, got_host, rdata, en_cyc, en_cnt, en_we, timeout);
    e = sb.pop_front();
    n_checks++;
    if (lat !== 3 || got_host !== e.host || rdata !== e.data || if1.core_rdata !== want[3])
      begin n_errors++; $display("FAIL host_read_isolation: ack_cycle=%0d host=%b rdata=%h core_rdata=%h, required 3/%b/%h/%h",
        lat, got_host, rdata, if1.core_rdata, e.host, e.data, want[3]); end
  endtask

  task automatic test_early_drop();
    int lat, en_cyc, en_cnt; bit got_host, en_we, timeout; logic [7:0] rdata; exp_t e;
    sb.push_back('{host: 1'b0, we: 1'b1, data: 8'h00});
    drive_txn(1'b0, 1'b0, 1'b1, 8'h40, 8'h77, 1'b1, lat, got_host, rdata, en_cyc, en_cnt, en_we, timeout);
    e = sb.pop_front();
    n_checks++;
    if (lat !== 2 || got_host !== e.host || mem1[8'h40] !== 8'h77)
      begin n_errors++; $display("FAIL early_drop_write: ack_cycle=%0d host=%b mem[40]=%h, required 2/%b/77",
        lat, got_host, mem1[8'h40], e.host); end
    sb.push_back('{host: 1'b0, we: 1'b0, data: 8'h77});
    drive_txn(1'b0, 1'b0, 1'b0, 8'h40, 8'h00, 1'b1, lat, got_host, rdata, en_cyc, en_cnt, en_we, timeout);
    e = sb.pop_front();
    n_checks++;
    if (lat !== 3 || got_host !== e.host || rdata !== e.data)
      begin n_errors++; $display("FAIL early_drop_read: ack_cycle=%0d host=%b rdata=%h, required 3/%b/%h",
        lat, got_host, rdata, e.host, e.data); end
  endtask

  task automatic test_reset_mid_wait();
    int lat, en_cyc, en_cnt; bit got_host, en_we, timeout; logic [7:0] rdata; exp_t e;
    bit seen;
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b1, 1'b0, 8'h02, 8'h00);
    @(posedge clk);
    @(posedge clk); #1;
    nreset = 1'b0;
    @(posedge clk); #1;
    nreset = 1'b1;
    set_req(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    n_checks++;
    if (if1.host_ack !== 1'b0 || if1.mem_en !== 1'b0 || if1.host_rdata !== 8'h00)
      begin n_errors++; $display("FAIL abort_outputs: host_ack=%b mem_en=%b host_rdata=%h, required 0/0/00",
        if1.host_ack, if1.mem_en, if1.host_rdata); end
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (if1.host_ack || if1.core_ack || if1.mem_en) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_errors++; $display("FAIL abort_quiet: activity after abort=%b, required 0", seen); end
    sb.push_back('{host: 1'b1, we: 1'b0, data: 8'h3E});
    drive_txn(1'b0, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0, lat, got_host, rdata, en_cyc, en_cnt, en_we, timeout);
    e = sb.pop_front();
    n_checks++;
    if (lat !== 3 || got_host !== e.host || rdata !== e.data)
      begin n_errors++; $display("FAIL after_abort_read: ack_cycle=%0d host=%b rdata=%h, required 3/%b/%h",
        lat, got_host, rdata, e.host, e.data); end
  endtask

  initial begin
    test_reset();
    test_core_write();
    test_read_latency();
    test_arbitration();
    test_loader();
    test_early_drop();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
